// File: rtl/mmio_timer_responder.sv
// mmio_timer_responder: MMIO timer peripheral answering req/ack bus accesses and raising a prescaled down-counter interrupt.
module mmio_timer_responder #(
    parameter int ACK_LAT = 1,
    parameter int PSC_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        irq
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;
    localparam logic [1:0] WAIT_INIT = 2'(ACK_LAT >= 2 ? ACK_LAT - 2 : 0);

    logic [1:0]       state_q, state_d, wcnt_q, wcnt_d;
    logic             held_q, held_d;
    logic [31:0]      rdata_q, rdata_d, preset_q, preset_d, count_q, count_d;
    logic             en_q, en_d, ar_q, ar_d, ie_q, ie_d, pend_q, pend_d;
    logic [PSC_W-1:0] psc_q, psc_d, pcnt_q, pcnt_d;
    logic             accept, go_ack, wr_ctrl, wr_pre, wr_st, tick, fire;
    logic [31:0]      rd_val;
    logic             unused_wdata;

    assign unused_wdata = ^wdata;

    always_comb begin
        // held_q blocks re-issue while the initiator keeps req high after its ack
        accept  = state_q == IDLE && cs && req && !held_q;
        go_ack  = (accept && ACK_LAT == 1) || (state_q == WAIT && wcnt_q == 2'd0);
        state_d = go_ack ? ACK : accept ? WAIT : state_q == ACK ? IDLE : state_q;
        wcnt_d  = accept ? WAIT_INIT : state_q == WAIT ? wcnt_q - 2'd1 : wcnt_q;
        held_d  = accept || (held_q && req);
        wr_ctrl = go_ack && we && addr == 2'd0;
        wr_pre  = go_ack && we && addr == 2'd1;
        wr_st   = go_ack && we && addr == 2'd3;
        rd_val  = addr == 2'd0 ? 32'({psc_q, 5'b0, ie_q, ar_q, en_q}) :
                  addr == 2'd1 ? preset_q :
                  addr == 2'd2 ? count_q : {31'b0, pend_q};
        rdata_d = go_ack ? rd_val : '0;
        tick    = en_q && pcnt_q == psc_q;
        fire    = tick && count_q == 32'd1;
        pcnt_d  = (wr_pre || tick) ? '0 : en_q ? pcnt_q + PSC_W'(1) : pcnt_q;
        count_d = wr_pre ? wdata : fire ? (ar_q ? preset_q : '0) :
                  (tick && count_q != '0) ? count_q - 32'd1 : count_q;
        pend_d  = (fire && !wr_pre) || (pend_q && !(wr_st && wdata[0]));
        preset_d = wr_pre ? wdata : preset_q;
        en_d    = wr_ctrl ? wdata[0] : en_q;
        ar_d    = wr_ctrl ? wdata[1] : ar_q;
        ie_d    = wr_ctrl ? wdata[2] : ie_q;
        psc_d   = wr_ctrl ? wdata[8 +: PSC_W] : psc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            held_q   <= 1'b0;
            rdata_q  <= '0;
            preset_q <= '0;
            count_q  <= '0;
            en_q     <= 1'b0;
            ar_q     <= 1'b0;
            ie_q     <= 1'b0;
            pend_q   <= 1'b0;
            psc_q    <= '0;
            pcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            held_q   <= held_d;
            rdata_q  <= rdata_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            en_q     <= en_d;
            ar_q     <= ar_d;
            ie_q     <= ie_d;
            pend_q   <= pend_d;
            psc_q    <= psc_d;
            pcnt_q   <= pcnt_d;
        end
    end

    assign ack   = state_q == ACK;
    assign rdata = rdata_q;
    assign irq   = pend_q && ie_q;
endmodule
